// File: rtl/random_state_checker.sv
// ---------------------------------------------------------------------------
// random_state_checker
//
// Receive-side companion to the random state generator. Samples a single-bit
// state line, measures every completed run (consecutive samples at one level)
// in clock cycles, and checks it against that level's [MIN, MAX] window.
// Each completed run produces a one-cycle length beat. Out-of-window runs
// raise err_o and bump a saturating error counter.
//
// Optional feature macro: RANDOM_STATE_CHECKER_EARLY_ERR_EN
//   defined   : overruns are flagged as soon as a run passes MAX, and the
//               closing-edge check of that run only looks for underruns.
//   undefined : every check happens at the closing edge of the run.
//
// Ports
//   clk_i        in   single clock, rising edge
//   s_rst_i      in   synchronous, active-high reset
//   state_i      in   monitored state line, synchronous to clk_i
//   len_valid_o  out  one-cycle pulse: a completed run is reported
//   len_o        out  length of the completed run (holds between beats)
//   len_state_o  out  level of the completed run (holds between beats)
//   err_o        out  one-cycle pulse: run length violation
//   err_cnt_o    out  saturating count of err_o pulses
// ---------------------------------------------------------------------------
module random_state_checker #(
  parameter int unsigned STATE_0_MIN_VAL = 10,
  parameter int unsigned STATE_0_MAX_VAL = 20,
  parameter int unsigned STATE_1_MIN_VAL = 30,
  parameter int unsigned STATE_1_MAX_VAL = 40,
  parameter int unsigned ERR_CNT_W       = 16,
  localparam int unsigned MAX_LEN = (STATE_0_MAX_VAL > STATE_1_MAX_VAL) ?
                                    STATE_0_MAX_VAL : STATE_1_MAX_VAL,
  // Wide enough that all-ones is strictly greater than either MAX.
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 2)
) (
  input  logic                 clk_i,
  input  logic                 s_rst_i,
  input  logic                 state_i,
  output logic                 len_valid_o,
  output logic [CNT_W-1:0]     len_o,
  output logic                 len_state_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  if (STATE_0_MIN_VAL == 0 || STATE_0_MIN_VAL > STATE_0_MAX_VAL ||
      STATE_1_MIN_VAL == 0 || STATE_1_MIN_VAL > STATE_1_MAX_VAL) begin : g_param_check
    $error("random_state_checker: each MIN_VAL must be >= 1 and <= its MAX_VAL");
  end

  localparam logic [CNT_W-1:0] MIN_0   = CNT_W'(STATE_0_MIN_VAL);
  localparam logic [CNT_W-1:0] MAX_0   = CNT_W'(STATE_0_MAX_VAL);
  localparam logic [CNT_W-1:0] MIN_1   = CNT_W'(STATE_1_MIN_VAL);
  localparam logic [CNT_W-1:0] MAX_1   = CNT_W'(STATE_1_MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    WAIT_EDGE,  // first edge after reset not yet seen; current run is partial
    MEASURE     // counting a run whose start was observed
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic                 state_q, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 len_valid_d;
  logic [CNT_W-1:0]     len_d;
  logic                 len_state_d;
  logic                 err_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  logic [CNT_W-1:0]     min_sel, max_sel, cnt_inc;
  logic                 under, over;

  // Window of the level currently being measured.
  assign min_sel = state_q ? MIN_1 : MIN_0;
  assign max_sel = state_q ? MAX_1 : MAX_0;
  assign under   = (cnt < min_sel);
  // A saturated count is all-ones, which always exceeds max_sel.
  assign over    = (cnt > max_sel);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
  // Set once this run's overrun has been reported, so the closing edge
  // does not report it a second time.
  logic early_flag, early_flag_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt;
    len_valid_d = 1'b0;
    len_d       = len_o;
    len_state_d = len_state_o;
    err_d       = 1'b0;
`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
    early_flag_d = early_flag;
`endif

    case (fsm_q)
      WAIT_EDGE: begin
        state_d = state_i;
        if (state_i != state_q) begin
          fsm_d = MEASURE;
          cnt_d = CNT_ONE;
        end
      end

      MEASURE: begin
        if (state_i == state_q) begin
          cnt_d = cnt_inc;
`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
          // Stepping from MAX to MAX+1: the run is already too long.
          if (cnt == max_sel && !early_flag) begin
            err_d        = 1'b1;
            early_flag_d = 1'b1;
          end
`endif
        end else begin
          len_valid_d = 1'b1;
          len_d       = cnt;
          len_state_d = state_q;
`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
          err_d        = under || (over && !early_flag);
          early_flag_d = 1'b0;
`else
          err_d        = under || over;
`endif
          cnt_d   = CNT_ONE;
          state_d = state_i;
        end
      end

      default: fsm_d = WAIT_EDGE;
    endcase

    // Counter is registered together with err_o so both move on the same edge.
    err_cnt_d = (err_d && err_cnt_o != '1) ? err_cnt_o + 1'b1 : err_cnt_o;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      fsm_q       <= WAIT_EDGE;
      state_q     <= 1'b0;
      cnt         <= '0;
      len_valid_o <= 1'b0;
      len_o       <= '0;
      len_state_o <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
      early_flag  <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt         <= cnt_d;
      len_valid_o <= len_valid_d;
      len_o       <= len_d;
      len_state_o <= len_state_d;
      err_o       <= err_d;
      err_cnt_o   <= err_cnt_d;
`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
      early_flag  <= early_flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_random_state_checker.sv
// ---------------------------------------------------------------------------
// tb_random_state_checker
//
// Self-checking bench for random_state_checker (default parameters).
// A run-level reference model predicts every output on every cycle; a table
// of runs with hand-derived beats, a few directed sequences and randomized
// run streams are applied on top of it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_random_state_checker;

`ifdef RANDOM_STATE_CHECKER_EARLY_ERR_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int CNT_W  = 6;        // $clog2(max(20, 40) + 2)
  localparam int SAT    = 63;       // all-ones of CNT_W
  localparam int ECNT_M = 65535;    // all-ones of ERR_CNT_W
  localparam int NV     = 15;

  logic                 clk_i   = 1'b0;
  logic                 s_rst_i = 1'b1;
  logic                 state_i = 1'b0;
  logic                 len_valid_o;
  logic [CNT_W-1:0]     len_o;
  logic                 len_state_o;
  logic                 err_o;
  logic [15:0]          err_cnt_o;

  random_state_checker dut (
    .clk_i       (clk_i),
    .s_rst_i     (s_rst_i),
    .state_i     (state_i),
    .len_valid_o (len_valid_o),
    .len_o       (len_o),
    .len_state_o (len_state_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lo_of(input logic lvl);
    return lvl ? 30 : 10;
  endfunction

  function automatic int hi_of(input logic lvl);
    return lvl ? 40 : 20;
  endfunction

  // ---------------- reference model (run-level view) ----------------
  logic m_prev;       // level of the previous sample
  logic m_in_run;     // a run with an observed start is being measured
  int   m_len;        // true (unbounded) length of that run
  logic e_valid, e_state, e_err;
  int   e_len, e_err_cnt;

  task automatic model_step();
    if (s_rst_i) begin
      m_prev = 1'b0; m_in_run = 1'b0; m_len = 0;
      e_valid = 1'b0; e_len = 0; e_state = 1'b0; e_err = 1'b0; e_err_cnt = 0;
    end else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (state_i != m_prev) begin
        if (m_in_run) begin
          e_valid = 1'b1;
          e_len   = (m_len > SAT) ? SAT : m_len;
          e_state = m_prev;
          e_err   = (m_len < lo_of(m_prev)) || ((m_len > hi_of(m_prev)) && !EARLY);
        end
        m_in_run = 1'b1;
        m_len    = 1;
      end else if (m_in_run) begin
        m_len++;
        if (EARLY && m_len == hi_of(m_prev) + 1) e_err = 1'b1;
      end
      m_prev = state_i;
      if (e_err && e_err_cnt < ECNT_M) e_err_cnt++;
    end
  endtask

  always @(posedge clk_i) model_step();

  // ---------------- monitor ----------------
  typedef struct {
    int   len;
    logic state;
    logic err;
    int   err_cnt;
  } beat_t;

  beat_t beats[$];
  logic  chk_en = 1'b0;
  logic  cap_en = 1'b0;
  logic  rnd_en = 1'b0;
  int    rnd_beats = 0;

  task automatic monitor_step();
    if (chk_en)
      check("cycle_model",
            64'({len_valid_o, len_o, len_state_o, err_o, err_cnt_o}),
            64'({e_valid, 6'(e_len), e_state, e_err, 16'(e_err_cnt)}));
    if (cap_en && len_valid_o)
      beats.push_back('{int'(len_o), len_state_o, err_o, int'(err_cnt_o)});
    if (rnd_en && len_valid_o) rnd_beats++;
  endtask

  always @(negedge clk_i) monitor_step();

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    s_rst_i = 1'b1;
    state_i = 1'b0;
    @(negedge clk_i);
    check("reset_state", 64'({len_valid_o, len_o, len_state_o, err_o, err_cnt_o}), 64'd0);
    s_rst_i = 1'b0;
  endtask

  // Hold lvl for n sampling edges; returns at a falling edge.
  task automatic drive(input logic lvl, input int n);
    state_i = lvl;
    repeat (n) @(negedge clk_i);
  endtask

  typedef struct {
    logic level;
    int   cycles;
    logic beat;     // this run is closed by the next entry and reported
    int   len;
    logic err;
    int   err_cnt;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    int   j, toggles, cyc, n;
    logic lvl;

    tbl[0]  = '{1'b0, 15, 1'b0,  0, 1'b0, 0};   // partial run after reset
    tbl[1]  = '{1'b1, 35, 1'b1, 35, 1'b0, 0};
    tbl[2]  = '{1'b0, 10, 1'b1, 10, 1'b0, 0};   // window edges
    tbl[3]  = '{1'b1, 30, 1'b1, 30, 1'b0, 0};
    tbl[4]  = '{1'b0, 20, 1'b1, 20, 1'b0, 0};
    tbl[5]  = '{1'b1, 40, 1'b1, 40, 1'b0, 0};
    tbl[6]  = '{1'b0,  9, 1'b1,  9, 1'b1, 1};   // underruns
    tbl[7]  = '{1'b1, 29, 1'b1, 29, 1'b1, 2};
    tbl[8]  = '{1'b0, 12, 1'b1, 12, 1'b0, 2};
    tbl[9]  = '{1'b1, 41, 1'b1, 41, !EARLY, 3}; // overrun
    tbl[10] = '{1'b0,  1, 1'b1,  1, 1'b1, 4};   // back-to-back beats
    tbl[11] = '{1'b1,  1, 1'b1,  1, 1'b1, 5};
    tbl[12] = '{1'b0,  1, 1'b1,  1, 1'b1, 6};
    tbl[13] = '{1'b1,  5, 1'b1,  5, 1'b1, 7};
    tbl[14] = '{1'b0, 10, 1'b0,  0, 1'b0, 0};   // left open

    @(negedge clk_i);
    do_reset();
    chk_en = 1'b1;

    // ---- table of runs ----
    beats.delete();
    cap_en = 1'b1;
    for (int i = 0; i < NV; i++) drive(tbl[i].level, tbl[i].cycles);
    cap_en = 1'b0;
    check("tbl_beat_count", 64'(beats.size()), 64'd13);
    j = 0;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].beat) begin
        if (j < beats.size()) begin
          check($sformatf("tbl%0d_len", i),     64'(beats[j].len),     64'(tbl[i].len));
          check($sformatf("tbl%0d_state", i),   64'(beats[j].state),   64'(tbl[i].level));
          check($sformatf("tbl%0d_err", i),     64'(beats[j].err),     64'(tbl[i].err));
          check($sformatf("tbl%0d_err_cnt", i), 64'(beats[j].err_cnt), 64'(tbl[i].err_cnt));
        end
        j++;
      end
    end

    // ---- overrun timing and counter saturation ----
    do_reset();
    drive(1'b0, 5);
    drive(1'b1, 41);
    check("early_err_after_41", 64'(err_o), 64'(EARLY));
    drive(1'b1, 28);                            // 69 = 2^6 + 5 samples at level 1
    state_i = 1'b0;
    @(negedge clk_i);
    check("saturated_beat",
          64'({len_valid_o, len_o, len_state_o, err_o, err_cnt_o}),
          64'({1'b1, 6'd63, 1'b1, !EARLY, 16'd1}));

    // ---- reset in the middle of a run ----
    do_reset();
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 20);
    check("pre_reset_len", 64'({len_o, len_state_o, err_cnt_o}), 64'({6'd4, 1'b0, 16'd2}));
    s_rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_run_reset", 64'({len_valid_o, len_o, len_state_o, err_o, err_cnt_o}), 64'd0);
    s_rst_i = 1'b0;
    state_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("no_beat_after_reset", 64'(len_valid_o), 64'd0);
    end

    // ---- legal random runs, as the generator would produce ----
    do_reset();
    drive(1'b0, 5);
    toggles   = 0;
    rnd_beats = 0;
    rnd_en    = 1'b1;
    lvl       = 1'b0;
    cyc       = 0;
    while (cyc < 15000) begin
      lvl = ~lvl;
      n   = lvl ? int'($urandom_range(40, 30)) : int'($urandom_range(20, 10));
      drive(lvl, n);
      toggles++;
      cyc += n;
    end
    rnd_en = 1'b0;
    check("rnd_beat_count", 64'(rnd_beats), 64'(toggles - 1));
    check("rnd_err_cnt", 64'(err_cnt_o), 64'd0);

    // ---- arbitrary random runs, including short and saturating ones ----
    do_reset();
    drive(1'b0, 3);
    lvl = 1'b0;
    cyc = 0;
    while (cyc < 8000) begin
      lvl = ~lvl;
      if ($urandom_range(3, 0) == 0) n = int'($urandom_range(3, 1));
      else                           n = int'($urandom_range(70, 1));
      drive(lvl, n);
      cyc += n;
    end
    drive(~lvl, 2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/random_state_checker.md
# random_state_checker

Receive-side companion to the random state generator: samples a single-bit state line and measures the length of every completed run, in clock cycles, for each level. It checks each run against that level's [MIN, MAX] window and reports a length beat for every completed run. It flags out-of-window runs and keeps a saturating error count. It sits on the bench or monitor side of any link driven by the generator, in the same clock domain.

## Interface
- STATE_0_MIN_VAL, 10, minimum legal run length (cycles) of level 0
- STATE_0_MAX_VAL, 20, maximum legal run length of level 0
- STATE_1_MIN_VAL, 30, minimum legal run length of level 1
- STATE_1_MAX_VAL, 40, maximum legal run length of level 1
- ERR_CNT_W, 16, width of error counter
- clk_i  input  1  single clock, all logic on rising edge
- s_rst_i  input  1  synchronous, active-high reset
- state_i  input  1  monitored state line, synchronous to clk_i
- len_valid_o  output  1  one-cycle pulse: completed run reported
- len_o  output  CNT_W  length of completed run, CNT_W = $clog2(max(STATE_0_MAX_VAL, STATE_1_MAX_VAL) + 2)
- len_state_o  output  1  level of the completed run
- err_o  output  1  one-cycle pulse: run length violation
- err_cnt_o  output  ERR_CNT_W  saturating count of err_o pulses

## Operation
- Elaboration check: each MIN_VAL >= 1 and MIN_VAL <= MAX_VAL, else $error.
- Registers: state_q (last sampled level), cnt (CNT_W, saturating at all-ones), FSM {WAIT_EDGE, MEASURE}.
- Reset values: FSM = WAIT_EDGE, state_q = 0, cnt = 0, len_valid_o = 0, len_o = 0, len_state_o = 0, err_o = 0, err_cnt_o = 0.
- WAIT_EDGE:
  - state_q <= state_i every cycle.
  - On state_i != state_q: go to MEASURE, cnt <= 1.
  - The run in progress at reset release is partial and is never reported.
- MEASURE, state_i == state_q: cnt <= cnt + 1, saturating at all-ones.
- MEASURE, state_i != state_q (closing edge):
  - len_o <= cnt, len_state_o <= state_q, len_valid_o <= 1.
  - err_o <= (cnt < MIN[state_q]) || (cnt > MAX[state_q]).
  - cnt <= 1, state_q <= state_i.
- A saturated cnt is reported as all-ones and is always an error, because all-ones > MAX.
- err_cnt_o increments on every err_o pulse and holds at all-ones. Only s_rst_i clears it.
- len_o and len_state_o hold their last reported values between beats.

## Timing
- Run length n means state_i was sampled at the same level on n consecutive rising edges.
- Closing edge sampled at edge k: len_valid_o, len_o, len_state_o and err_o are visible in the cycle after edge k. Latency is 1 cycle.
- Minimum run length 1: back-to-back beats on consecutive cycles are legal and each is reported.
- err_cnt_o updates in the same cycle err_o is high, i.e. it is registered together with err_o.
- s_rst_i asserted mid-run:
  - All outputs return to reset values on the next edge.
  - The FSM re-enters WAIT_EDGE, and the interrupted run is discarded.

## Configuration
- RANDOM_STATE_CHECKER_EARLY_ERR_EN defined: overrun detected early.
  - When cnt would step from MAX[state_q] to MAX[state_q]+1 in MEASURE, err_o pulses in the following cycle and err_cnt_o increments.
  - A per-run flag suppresses a second error at that run's closing edge; len_valid_o still pulses with the real length.
  - Underruns are still flagged at the closing edge.
- Undefined: all checks happen at the closing edge only, and no per-run flag is built.

## Test plan
- Reset, then state_i = 0 for 15 cycles, 1 for 35, then 0 -> no beat for the first run; one beat with len_o = 35, len_state_o = 1, err_o = 0.
- Boundary runs 0 for 10, 1 for 30, 0 for 20, 1 for 40 -> four beats with lengths 10/30/20/40, err_o = 0 throughout, err_cnt_o = 0.
- 0 for 9 cycles, 1 for 29 cycles -> both beats carry err_o = 1; err_cnt_o reads 1, then 2.
- 1 for 41 cycles:
  - Macro undefined: err_o arrives with the beat, len_o = 41.
  - Macro defined: err_o arrives the cycle after the 41st sample; the beat carries err_o = 0.
  - err_cnt_o = 1 in both cases.
- Hold 1 for 2^CNT_W + 5 cycles, then toggle -> len_o = all-ones, err_o = 1. Separately, assert s_rst_i at cycle 20 of a level-1 run -> outputs zero, and the next edge produces no beat.
- Drive state_i from the random state generator (default parameters) for 100000 cycles -> every beat is within its window, err_cnt_o = 0, and the count of len_valid_o pulses equals the generator toggles minus 1.
